frame_pixel_streamer: RTL and testbench

FRAME_PIXEL_STREAMER -- requirements
Module: frame_pixel_streamer

---
 rtl/frame_pixel_streamer.sv | 156 +++++++++++++++
 tb/tb_frame_pixel_streamer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer: reads a finished frame out of a frame buffer and
// streams it as valid/ready pixels with column/row tags.
// A 4-entry FIFO absorbs downstream stalls. Reads are only issued while
// FIFO occupancy plus reads in flight leaves room for the new word.
// Optional build macro FRAME_PIXEL_STREAMER_THRESHOLD_EN binarizes each
// pixel against THRESH as it is captured.
module frame_pixel_streamer #(
   parameter int         WIDTH      = 28,
   parameter int         HEIGHT     = 28,
   parameter int         NUM_PIXELS = WIDTH * HEIGHT,
   parameter logic [7:0] THRESH     = 8'd128
) (
   input  logic                      pix_clk,
   input  logic                      rst_n,
   input  logic                      frame_done,
   output logic                      rd_en,
   output logic [9:0]                rd_addr,
   input  logic [7:0]                rd_data,
   output logic                      pix_valid,
   input  logic                      pix_ready,
   output logic [7:0]                pix_data,
   output logic [$clog2(WIDTH)-1:0]  pix_col,
   output logic [$clog2(HEIGHT)-1:0] pix_row,
   output logic                      pix_last,
   output logic                      busy,
   output logic                      frame_drop
);

   localparam int         CW        = $clog2(WIDTH);
   localparam int         RW        = $clog2(HEIGHT);
   localparam logic [9:0] LAST_ADDR = 10'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t      state, state_next;
   logic        rd_en_next;
   logic [9:0]  rd_addr_next;
   logic        frame_drop_next;
   logic        data_valid;
   logic [7:0]  fifo_mem [4];
   logic [1:0]  wr_ptr, rd_ptr;
   logic [2:0]  fifo_count, count_after;
   logic [3:0]  committed;
   logic        push, pop, can_issue;
   logic [7:0]  push_data;

`ifdef FRAME_PIXEL_STREAMER_THRESHOLD_EN
   assign push_data = (rd_data >= THRESH) ? 8'hFF : 8'h00;
`else
   logic unused_thresh;
   assign unused_thresh = ^THRESH;
   assign push_data     = rd_data;
`endif

   assign push      = data_valid;
   assign pix_valid = (fifo_count != 3'd0);
   assign pop       = pix_valid & pix_ready;
   assign pix_data  = pix_valid ? fifo_mem[rd_ptr] : 8'h00;
   assign pix_last  = (pix_row == RW'(HEIGHT - 1)) && (pix_col == CW'(WIDTH - 1));
   assign busy      = (state != IDLE);

   // Look ahead one edge: a new read is allowed only if every word already
   // owed to the FIFO plus this one still fits in its four entries.
   always_comb begin
      count_after = fifo_count + {2'b00, push} - {2'b00, pop};
      committed   = {1'b0, count_after} + {3'b000, rd_en} + 4'd1;
      can_issue   = (committed <= 4'd4);
   end

   // Next-state and read-issue decisions; the frame is fully requested once
   // the last address has gone out, after which only the FIFO drains.
   always_comb begin
      state_next      = state;
      rd_en_next      = 1'b0;
      rd_addr_next    = rd_addr;
      frame_drop_next = frame_done && (state != IDLE);
      case (state)
         IDLE: begin
            if (frame_done) begin
               state_next   = READ;
               rd_en_next   = 1'b1;
               rd_addr_next = 10'd0;
            end
         end
         READ: begin
            if (rd_addr == LAST_ADDR) begin
               state_next = DRAIN;
            end else if (can_issue) begin
               rd_en_next   = 1'b1;
               rd_addr_next = rd_addr + 10'd1;
            end
         end
         DRAIN: begin
            if (pop && pix_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Control registers; reset drops any read in flight so a broken frame
   // leaves nothing behind.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rd_en      <= 1'b0;
         rd_addr    <= 10'd0;
         data_valid <= 1'b0;
         frame_drop <= 1'b0;
      end else begin
         state      <= state_next;
         rd_en      <= rd_en_next;
         rd_addr    <= rd_addr_next;
         data_valid <= rd_en;
         frame_drop <= frame_drop_next;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= 2'd0;
         rd_ptr     <= 2'd0;
         fifo_count <= 3'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         fifo_count <= count_after;
      end
   end

   // FIFO storage needs no reset because the output is masked when empty.
   always_ff @(posedge pix_clk) begin
      if (push) fifo_mem[wr_ptr] <= push_data;
   end

   // Raster position of the pixel at the FIFO head, advanced per handshake.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_col <= '0;
         pix_row <= '0;
      end else if (pop) begin
         if (pix_last) begin
            pix_col <= '0;
            pix_row <= '0;
         end else if (pix_col == CW'(WIDTH - 1)) begin
            pix_col <= '0;
            pix_row <= pix_row + RW'(1);
         end else begin
            pix_col <= pix_col + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// tb_frame_pixel_streamer: drives frames through frame_pixel_streamer from a
// modelled frame buffer and checks the pixel stream against a raster model.
module tb_frame_pixel_streamer;

   localparam int W  = 28;
   localparam int H  = 28;
   localparam int NP = W * H;

   logic       pix_clk, rst_n, frame_done, rd_en, pix_valid, pix_ready;
   logic       pix_last, busy, frame_drop;
   logic [9:0] rd_addr;
   logic [7:0] rd_data, pix_data;
   logic [4:0] pix_col, pix_row;

   frame_pixel_streamer dut (
      .pix_clk(pix_clk), .rst_n(rst_n), .frame_done(frame_done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .pix_col(pix_col), .pix_row(pix_row), .pix_last(pix_last),
      .busy(busy), .frame_drop(frame_drop)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0]  mem [1024];
   logic [18:0] obs_q [$];
   logic [18:0] cur_out, prev_out;
   logic        prev_stall;
   int          reads_total = 0, outstanding = 0;
   int          stab_err = 0, over_err = 0, drop_pulses = 0;

   assign cur_out = {pix_data, pix_col, pix_row, pix_last};

   initial pix_clk = 1'b0;
   always #5 pix_clk = ~pix_clk;

   // Frame buffer: data appears the cycle after the read request.
   always @(posedge pix_clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   // Observer: records handshaken pixels and tallies protocol breaches.
   always @(negedge pix_clk) begin
      if (!rst_n) begin
         prev_stall  <= 1'b0;
         outstanding <= 0;
      end else begin
         if (rd_en) begin
            reads_total <= reads_total + 1;
            if (outstanding + 1 > 4) over_err <= over_err + 1;
         end
         if (prev_stall && (!pix_valid || cur_out != prev_out)) stab_err <= stab_err + 1;
         if (pix_valid && pix_ready) obs_q.push_back(cur_out);
         if (frame_drop) drop_pulses <= drop_pulses + 1;
         outstanding <= outstanding + (rd_en ? 1 : 0) - ((pix_valid && pix_ready) ? 1 : 0);
         prev_stall  <= pix_valid && !pix_ready;
         prev_out    <= cur_out;
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required frames to finish");
      $fatal(1, "[TB] watchdog");
   end

   // Expected pixel k of a frame: raster position from k, value from buffer.
   function automatic logic [18:0] exp_pixel(input int k);
      logic [7:0] d;
      d = mem[k];
`ifdef FRAME_PIXEL_STREAMER_THRESHOLD_EN
      d = (d >= 8'd128) ? 8'hFF : 8'h00;
`endif
      return {d, 5'(k % W), 5'(k / W), (k == NP - 1)};
   endfunction

   task automatic fill_mem(input int random_fill);
      for (int i = 0; i < 1024; i++) mem[i] = random_fill ? 8'($urandom) : 8'(i);
   endtask

   task automatic apply_frame_done();
      @(posedge pix_clk); #2 frame_done = 1'b1;
      @(posedge pix_clk); #2 frame_done = 1'b0;
   endtask

   // Runs cycles until the frame ends or stop_at pixels were seen.
   // mode 0: ready high, 1: pattern 1,0,0,1, 2: random ready.
   task automatic run_stream(input int mode, input int base, input int drop_a,
                             input int drop_b, input int stop_at,
                             input int max_cyc, output int cycles);
      logic [3:0] pat;
      int n;
      pat = 4'b1001;
      cycles = 0;
      while (cycles < max_cyc) begin
         @(posedge pix_clk); #2;
         n = obs_q.size() - base;
         frame_done = (n == drop_a) || (n == drop_b);
         case (mode)
            0: pix_ready = 1'b1;
            1: pix_ready = pat[cycles % 4];
            default: pix_ready = 1'($urandom_range(0, 1));
         endcase
         cycles++;
         if (!busy || n == stop_at) break;
      end
      frame_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; frame_done = 1'b0; pix_ready = 1'b0;
      #3;
      total++;
      if ({rd_en, rd_addr, pix_valid, pix_data, pix_col, pix_row, pix_last, busy, frame_drop} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got %h required 0",
                  {rd_en, rd_addr, pix_valid, pix_data, pix_col, pix_row, pix_last, busy, frame_drop});
      end
      repeat (2) @(posedge pix_clk);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge pix_clk);
      #2;
      total++;
      if (busy !== 1'b0 || rd_en !== 1'b0) begin
         bad++;
         $display("[TB] FAIL idle_after_reset: busy=%b rd_en=%b required 0 0", busy, rd_en);
      end
   endtask

   task automatic test_basic();
      int base, cyc, drops0;
      fill_mem(0);
      pix_ready = 1'b1;
      base = obs_q.size(); drops0 = drop_pulses;
      apply_frame_done();
      total++;
      if (rd_en !== 1'b1 || rd_addr !== 10'd0 || busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL first_read: rd_en=%b rd_addr=%0d busy=%b required 1 0 1", rd_en, rd_addr, busy);
      end
      @(posedge pix_clk); #2;
      total++;
      if (pix_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL early_valid: pix_valid=%b required 0", pix_valid);
      end
      @(posedge pix_clk); #2;
      total++;
      if (pix_valid !== 1'b1 || pix_data !== 8'h00) begin
         bad++;
         $display("[TB] FAIL first_pixel: pix_valid=%b pix_data=%h required 1 00", pix_valid, pix_data);
      end
      run_stream(0, base, -1, -1, -1, 5000, cyc);
      total++;
      if (cyc != NP) begin
         bad++;
         $display("[TB] FAIL stream_cycles: took %0d cycles required %0d", cyc, NP);
      end
      for (int k = 0; k < NP; k++) begin
         total++;
         if (base + k >= obs_q.size() || obs_q[base + k] !== exp_pixel(k)) begin
            bad++;
            $display("[TB] FAIL basic_pixel[%0d]: got %h required %h", k,
                     (base + k < obs_q.size()) ? obs_q[base + k] : 19'h0, exp_pixel(k));
         end
      end
      repeat (3) @(posedge pix_clk); #2;
      total++;
      if (busy !== 1'b0 || drop_pulses != drops0) begin
         bad++;
         $display("[TB] FAIL basic_end: busy=%b drops=%0d required 0 0", busy, drop_pulses - drops0);
      end
   endtask

   task automatic test_stall();
      int base, cyc, reads0, stab0;
      fill_mem(0);
      pix_ready = 1'b0;
      base = obs_q.size(); reads0 = reads_total; stab0 = stab_err;
      apply_frame_done();
      repeat (50) @(posedge pix_clk);
      #2;
      total++;
      if (reads_total - reads0 != 4) begin
         bad++;
         $display("[TB] FAIL stall_reads: issued %0d required 4", reads_total - reads0);
      end
      total++;
      if (pix_valid !== 1'b1 || pix_data !== 8'h00 || pix_col !== 5'd0 || pix_row !== 5'd0) begin
         bad++;
         $display("[TB] FAIL stall_head: valid=%b data=%h col=%0d row=%0d required 1 00 0 0",
                  pix_valid, pix_data, pix_col, pix_row);
      end
      run_stream(0, base, -1, -1, -1, 5000, cyc);
      for (int k = 0; k < NP; k++) begin
         total++;
         if (base + k >= obs_q.size() || obs_q[base + k] !== exp_pixel(k)) begin
            bad++;
            $display("[TB] FAIL stall_pixel[%0d]: got %h required %h", k,
                     (base + k < obs_q.size()) ? obs_q[base + k] : 19'h0, exp_pixel(k));
         end
      end
      total++;
      if (stab_err != stab0) begin
         bad++;
         $display("[TB] FAIL stall_stable: %0d unstable cycles required 0", stab_err - stab0);
      end
   endtask

   task automatic test_backpressure(input int mode, input int fixed_head);
      int base, cyc, stab0, over0;
      fill_mem(1);
      if (fixed_head != 0) begin
         mem[0] = 8'd127; mem[1] = 8'd128; mem[2] = 8'd255; mem[3] = 8'd0;
      end
      pix_ready = 1'b1;
      base = obs_q.size(); stab0 = stab_err; over0 = over_err;
      apply_frame_done();
      run_stream(mode, base, -1, -1, -1, 8000, cyc);
      total++;
      if (cyc >= 8000) begin
         bad++;
         $display("[TB] FAIL bp_timeout: mode %0d ran %0d cycles required under 8000", mode, cyc);
      end
      for (int k = 0; k < NP; k++) begin
         total++;
         if (base + k >= obs_q.size() || obs_q[base + k] !== exp_pixel(k)) begin
            bad++;
            $display("[TB] FAIL bp%0d_pixel[%0d]: got %h required %h", mode, k,
                     (base + k < obs_q.size()) ? obs_q[base + k] : 19'h0, exp_pixel(k));
         end
      end
      total++;
      if (stab_err != stab0 || over_err != over0) begin
         bad++;
         $display("[TB] FAIL bp%0d_protocol: unstable=%0d overcommit=%0d required 0 0",
                  mode, stab_err - stab0, over_err - over0);
      end
   endtask

   task automatic test_drop();
      int base1, base2, cyc, drops0;
      fill_mem(1);
      pix_ready = 1'b1;
      base1 = obs_q.size(); drops0 = drop_pulses;
      apply_frame_done();
      run_stream(0, base1, 300, NP - 1, -1, 5000, cyc);
      frame_done = 1'b1;
      @(posedge pix_clk); #2 frame_done = 1'b0;
      total++;
      if (rd_en !== 1'b1 || rd_addr !== 10'd0 || busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL restart: rd_en=%b rd_addr=%0d busy=%b required 1 0 1", rd_en, rd_addr, busy);
      end
      base2 = base1 + NP;
      run_stream(0, base2, -1, -1, -1, 5000, cyc);
      for (int k = 0; k < 2 * NP; k++) begin
         total++;
         if (base1 + k >= obs_q.size() || obs_q[base1 + k] !== exp_pixel(k % NP)) begin
            bad++;
            $display("[TB] FAIL drop_pixel[%0d]: got %h required %h", k,
                     (base1 + k < obs_q.size()) ? obs_q[base1 + k] : 19'h0, exp_pixel(k % NP));
         end
      end
      total++;
      if (drop_pulses - drops0 != 2) begin
         bad++;
         $display("[TB] FAIL drop_count: saw %0d drop cycles required 2", drop_pulses - drops0);
      end
   endtask

   task automatic test_midreset();
      int base, cyc;
      fill_mem(1);
      pix_ready = 1'b1;
      base = obs_q.size();
      apply_frame_done();
      run_stream(0, base, -1, -1, 400, 5000, cyc);
      rst_n = 1'b0;
      #1;
      total++;
      if ({rd_en, rd_addr, pix_valid, pix_data, pix_col, pix_row, pix_last, busy, frame_drop} !== '0) begin
         bad++;
         $display("[TB] FAIL midreset_outputs: got %h required 0",
                  {rd_en, rd_addr, pix_valid, pix_data, pix_col, pix_row, pix_last, busy, frame_drop});
      end
      repeat (3) @(posedge pix_clk);
      #2 rst_n = 1'b1;
      repeat (5) @(posedge pix_clk);
      #2;
      total++;
      if (busy !== 1'b0 || pix_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midreset_idle: busy=%b pix_valid=%b required 0 0", busy, pix_valid);
      end
      base = obs_q.size();
      apply_frame_done();
      total++;
      if (rd_en !== 1'b1 || rd_addr !== 10'd0) begin
         bad++;
         $display("[TB] FAIL midreset_restart: rd_en=%b rd_addr=%0d required 1 0", rd_en, rd_addr);
      end
      run_stream(0, base, -1, -1, -1, 5000, cyc);
      for (int k = 0; k < NP; k++) begin
         total++;
         if (base + k >= obs_q.size() || obs_q[base + k] !== exp_pixel(k)) begin
            bad++;
            $display("[TB] FAIL midreset_pixel[%0d]: got %h required %h", k,
                     (base + k < obs_q.size()) ? obs_q[base + k] : 19'h0, exp_pixel(k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_backpressure(1, 0);
      test_backpressure(2, 1);
      test_drop();
      test_midreset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
